obf_seqctrl: RTL
================

OBF_SEQCTRL -- requirements
Module: obf_seqctrl

Interface
REQ-001 SHALL have parameter OBF_PPC_WIDTH, default 3, width of the partial-PC (sub-instruction index) counter.
REQ-002 SHALL have parameter OBF_KEY_WIDTH, default 2, width of the obfuscation key register.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_insn  in  32  reference instruction from fetch.
REQ-006 if_valid / if_ready  in / out  1 / 1  fetch handshake; transfer occurs when both are high.
REQ-007 flush  in  1  synchronous pipeline flush.
REQ-008 obf_en  in  1  obfuscation enable, sampled at accept.
REQ-009 key_we / key_i  in / in  1 / OBF_KEY_WIDTH  key write request and value.
REQ-010 gen_ref_insn / gen_ppc / gen_key  out / out / out  32 / OBF_PPC_WIDTH / OBF_KEY_WIDTH  drive the instruction-generator inputs from registers.
REQ-011 gen_insn / gen_last / gen_skip  in / in / in  32 / 1 / 1  instruction-generator outputs; combinational from the gen_* outputs.
REQ-012 id_insn / id_valid / id_ready  out / out / in  32 / 1 / 1  decode handshake; transfer occurs when valid and ready are both high.
REQ-013 id_first / id_skip  out / out  1 / 1  qualify id_insn: first sub-instruction of a sequence; generator skip flag.
REQ-014 busy / seq_err  out / out  1 / 1  sequence in progress; sticky overrun error.

Function
REQ-015 FSM states SHALL be IDLE and EXPAND.
REQ-016 Output slot is a single register (id_insn, id_first, id_skip, id_valid). slot_free = !id_valid || id_ready.
REQ-017 if_ready SHALL be high only when state==IDLE, slot_free, no pending key, and flush is low.
REQ-018 Accept in IDLE SHALL latch ref_q=if_insn, en_q=obf_en, ppc=0, and move to EXPAND; busy=1 from the next cycle.
REQ-019 In EXPAND with slot_free, each cycle SHALL load the slot as follows:
  - en_q=1: id_insn=gen_insn, id_skip=gen_skip.
  - en_q=0: id_insn=ref_q, id_skip=0.
  - id_first=(ppc==0); id_valid=1.
REQ-020 End condition: en_q=0, or gen_last=1, or ppc==2^OBF_PPC_WIDTH-1.
  - End SHALL return the FSM to IDLE with ppc=0.
  - Otherwise ppc SHALL increment by 1.
REQ-021 Reaching ppc==2^OBF_PPC_WIDTH-1 with gen_last=0 and en_q=1 SHALL terminate the sequence and set seq_err=1; seq_err stays set until rst.
REQ-022 In EXPAND with !slot_free, ppc, ref_q and the slot SHALL hold.
REQ-023 Latency: accept in cycle N puts the first sub-instruction on id at cycle N+2. Each following sub-instruction takes one cycle when id_ready is held high.
REQ-024 gen_ref_insn=ref_q, gen_ppc=ppc, gen_key=key_q, all held stable for the whole sequence.
REQ-025 key_we in IDLE with no sequence starting SHALL load key_q=key_i on the next edge.
REQ-026 key_we in EXPAND, or while accepting, SHALL store the value in key_pend and set pend=1. The pending key SHALL be applied on the first IDLE cycle; the last write wins.
REQ-027 flush SHALL, on the next edge:
  - clear id_valid;
  - set state=IDLE and ppc=0;
  - leave key_q, key_pend and seq_err unchanged.
  flush beats accept and slot load in the same cycle.
REQ-028 id_valid with id_ready low SHALL hold id_insn, id_first and id_skip stable.

Reset
REQ-029 rst SHALL force, on the next edge:
  - state=IDLE, ppc=0, ref_q=0, en_q=0;
  - key_q=0, pend=0;
  - id_valid=0, id_insn=0, id_first=0, id_skip=0;
  - busy=0, seq_err=0.
REQ-030 rst SHALL override flush, key_we and every handshake in the same cycle. if_ready is 0 during any cycle in which rst is high.

Verification
REQ-031 obf_en=1, if_insn=0xE0632000, generator gen_last=1 at ppc=2, id_ready=1 -> 3 id transfers with gen_ppc 0,1,2; id_first=1 only on the first; busy low after the third; if_ready high the cycle after.
REQ-032 obf_en=0, if_insn=0x9C210004 -> exactly one id transfer with id_insn=0x9C210004, id_first=1, id_skip=0.
REQ-033 Generator never asserts gen_last, OBF_PPC_WIDTH=3 -> 8 transfers (ppc 0..7), then seq_err=1 and FSM returns to IDLE.
REQ-034 id_ready held low 3 cycles mid-sequence at ppc=1 -> id_insn and gen_ppc stable, no sub-instruction lost or duplicated after release.
REQ-035 key_we with key_i=2'b11 at ppc=1 of an active sequence -> gen_key unchanged until the sequence ends; key_q=3 on the first IDLE cycle; if_ready stays low that cycle.
REQ-036 flush at ppc=2 with id_valid=1 -> next cycle id_valid=0, busy=0, ppc=0; a subsequent if_valid is accepted and restarts at ppc=0.

Source files
------------

// File: rtl/obf_seqctrl.sv
// Obfuscating sequence controller: expands each fetched instruction into a
// run of generator sub-instructions (or passes it through) toward decode.
module obf_seqctrl #(
  parameter int OBF_PPC_WIDTH = 3,
  parameter int OBF_KEY_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              if_insn,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic                     flush,
  input  logic                     obf_en,
  input  logic                     key_we,
  input  logic [OBF_KEY_WIDTH-1:0] key_i,
  output logic [31:0]              gen_ref_insn,
  output logic [OBF_PPC_WIDTH-1:0] gen_ppc,
  output logic [OBF_KEY_WIDTH-1:0] gen_key,
  input  logic [31:0]              gen_insn,
  input  logic                     gen_last,
  input  logic                     gen_skip,
  output logic [31:0]              id_insn,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic                     id_first,
  output logic                     id_skip,
  output logic                     busy,
  output logic                     seq_err
);

  typedef enum logic {IDLE, EXPAND} state_e;

  localparam logic [OBF_PPC_WIDTH-1:0] PPC_MAX = '1;
  localparam logic [OBF_PPC_WIDTH-1:0] PPC_ONE = OBF_PPC_WIDTH'(1);

  state_e                     state_q;
  logic [OBF_PPC_WIDTH-1:0]   ppc_q;
  logic [31:0]                ref_q;
  logic                       en_q;
  logic [OBF_KEY_WIDTH-1:0]   key_q;
  logic [OBF_KEY_WIDTH-1:0]   key_pend_q;
  logic                       pend_q;
  logic [31:0]                id_insn_q;
  logic                       id_valid_q;
  logic                       id_first_q;
  logic                       id_skip_q;
  logic                       busy_q;
  logic                       seq_err_q;

  logic slot_free;
  logic accept;
  logic ppc_max;
  logic seq_end;

  always_comb begin
    slot_free = !id_valid_q || id_ready;
    if_ready  = !rst && (state_q == IDLE) && slot_free && !pend_q && !flush;
    accept    = if_valid && if_ready;
    ppc_max   = (ppc_q == PPC_MAX);
    seq_end   = !en_q || gen_last || ppc_max;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ppc_q      <= '0;
      ref_q      <= '0;
      en_q       <= 1'b0;
      key_q      <= '0;
      key_pend_q <= '0;
      pend_q     <= 1'b0;
      id_insn_q  <= '0;
      id_valid_q <= 1'b0;
      id_first_q <= 1'b0;
      id_skip_q  <= 1'b0;
      busy_q     <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      if (id_valid_q && id_ready) begin
        id_valid_q <= 1'b0;
      end

      // Key writes that would disturb a live sequence are parked until IDLE.
      if (!flush) begin
        if (key_we && (state_q == EXPAND || accept)) begin
          key_pend_q <= key_i;
          pend_q     <= 1'b1;
        end else if (state_q == IDLE) begin
          if (key_we) begin
            key_q  <= key_i;
            pend_q <= 1'b0;
          end else if (pend_q) begin
            key_q  <= key_pend_q;
            pend_q <= 1'b0;
          end
        end
      end

      if (flush) begin
        state_q    <= IDLE;
        ppc_q      <= '0;
        busy_q     <= 1'b0;
        id_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              ref_q   <= if_insn;
              en_q    <= obf_en;
              ppc_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= EXPAND;
            end
          end
          EXPAND: begin
            if (slot_free) begin
              id_insn_q  <= en_q ? gen_insn : ref_q;
              id_skip_q  <= en_q ? gen_skip : 1'b0;
              id_first_q <= (ppc_q == '0);
              id_valid_q <= 1'b1;
              if (seq_end) begin
                state_q <= IDLE;
                ppc_q   <= '0;
                busy_q  <= 1'b0;
                if (en_q && !gen_last && ppc_max) begin
                  seq_err_q <= 1'b1;
                end
                // Expose the parked key on the first IDLE cycle; pend_q stays
                // set through that cycle so no new sequence starts with it.
                if (key_we) begin
                  key_q <= key_i;
                end else if (pend_q) begin
                  key_q <= key_pend_q;
                end
              end else begin
                ppc_q <= ppc_q + PPC_ONE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign gen_ref_insn = ref_q;
  assign gen_ppc      = ppc_q;
  assign gen_key      = key_q;
  assign id_insn      = id_insn_q;
  assign id_valid     = id_valid_q;
  assign id_first     = id_first_q;
  assign id_skip      = id_skip_q;
  assign busy         = busy_q;
  assign seq_err      = seq_err_q;

endmodule
